// File: rtl/usb_pkg.sv
// Shared USB transmit-side definitions: PID type codes, PID values and the
// packet arbiter state encoding.
package usb_pkg;

    localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
    localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } tx_arb_state_t;

endpackage

// File: rtl/usb_tx_gap_timer.sv
// Loadable down-counter with zero flag; one instance serves both the
// completion watchdog and the inter-packet gap.
module usb_tx_gap_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/usb_tx_pkt_arb.sv
// Shares the token/handshake packet transmitter between the handshake
// responder and the token issuer: arbitrate, check PID type, start, wait, gap.
module usb_tx_pkt_arb
    import usb_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int HS_MAX_RUN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_valid,
    output logic       hs_ready,
    input  logic [3:0] hs_pid,
    input  logic       tk_valid,
    output logic       tk_ready,
    input  logic [3:0] tk_pid,
    input  logic [6:0] tk_addr,
    input  logic [3:0] tk_endp,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [3:0] tx_pid,
    output logic [6:0] tx_addr,
    output logic [3:0] tx_endp,
    output logic       hs_done,
    output logic       tk_done,
    output logic       pid_err,
    output logic       tx_timeout,
    output logic       busy
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(HS_MAX_RUN + 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    // The counter is loaded with N-1 so that "zero" marks the last cycle.
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(HS_MAX_RUN);

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
        return (r == RUN_MAX) ? RUN_MAX : r + RUN_W'(1);
    endfunction

    tx_arb_state_t    state;
    logic             src_tk;
    logic [RUN_W-1:0] run_cnt;

    logic             tk_win;
    logic             wd_first;
    logic             pkt_complete;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_cnt;

    assign tk_win   = tk_valid && (!hs_valid || (run_cnt == RUN_MAX));
    assign hs_ready = (state == ST_IDLE) && hs_valid && !tk_win;
    assign tk_ready = (state == ST_IDLE) && tk_win;
    assign tx_valid = (state == ST_ISSUE) && tx_ready;
    assign busy     = (state != ST_IDLE);

    // The transmitter still shows ready in the first WAIT_DONE cycle.
    assign wd_first     = (tmr_cnt == TO_LOAD);
    assign pkt_complete = (state == ST_WAIT_DONE) && !wd_first && tx_ready;
    assign tx_timeout   = (state == ST_WAIT_DONE) && !pkt_complete && tmr_zero;

    assign tmr_load     = tx_valid || (HAS_GAP && (pkt_complete || tx_timeout));
    assign tmr_load_val = (state == ST_ISSUE) ? TO_LOAD : GAP_LOAD;
    assign tmr_dec      = (state == ST_WAIT_DONE) || (state == ST_GAP);

    usb_tx_gap_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_load_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            src_tk  <= 1'b0;
            run_cnt <= '0;
            tx_pid  <= '0;
            tx_addr <= '0;
            tx_endp <= '0;
            hs_done <= 1'b0;
            tk_done <= 1'b0;
            pid_err <= 1'b0;
        end else begin
            hs_done <= 1'b0;
            tk_done <= 1'b0;
            pid_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hs_ready) begin
                        tx_pid  <= hs_pid;
                        tx_addr <= '0;
                        tx_endp <= '0;
                        src_tk  <= 1'b0;
                        run_cnt <= tk_valid ? run_sat_inc(run_cnt) : '0;
                        if (hs_pid[1:0] == PID_TYPE_HANDSHAKE) state <= ST_ISSUE;
                        else                                   pid_err <= 1'b1;
                    end else if (tk_ready) begin
                        tx_pid  <= tk_pid;
                        tx_addr <= tk_addr;
                        tx_endp <= tk_endp;
                        src_tk  <= 1'b1;
                        run_cnt <= '0;
                        if (tk_pid[1:0] == PID_TYPE_TOKEN) state <= ST_ISSUE;
                        else                               pid_err <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (tx_ready) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (pkt_complete) begin
                        hs_done <= !src_tk;
                        tk_done <= src_tk;
                        state   <= HAS_GAP ? ST_GAP : ST_IDLE;
                    end else if (tx_timeout) begin
                        state   <= HAS_GAP ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (tmr_zero) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
